// File: rtl/syn_global_pkg.sv
// rtl/syn_global_pkg.sv - shared widths, PCM pair type and I2S receiver state encoding
//
// Purpose: common widths used across the audio path, the stereo pair layout and
//          the state encoding of the ADC I2S receiver.
// Ports:   none (package).
package syn_global_pkg;

  localparam int P_16B_W = 16;
  localparam int P_32B_W = 32;

  typedef struct packed {
    logic [P_16B_W-1:0] l;
    logic [P_16B_W-1:0] r;
  } pcm_pair_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_LRC = 3'd1,
    ST_SKIP_L   = 3'd2,
    ST_LEFT     = 3'd3,
    ST_SKIP_R   = 3'd4,
    ST_RIGHT    = 3'd5
  } i2s_rx_state_e;

endpackage

// File: rtl/syn_sync_edge.sv
// rtl/syn_sync_edge.sv - N-stage synchroniser with single-cycle rise/fall pulses
//
// Purpose: brings a slow asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk    in   system clock
//   rst_l  in   synchronous active-low reset (clears all stages to 0)
//   din    in   asynchronous input
//   level  out  synchronised level
//   rise   out  one-cycle pulse on synchronised 0->1
//   fall   out  one-cycle pulse on synchronised 1->0
module syn_sync_edge #(
  parameter int P_STAGES = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [P_STAGES-1:0] sync_q;
  logic                prev_q;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[P_STAGES-2:0], din};
      prev_q <= sync_q[P_STAGES-1];
    end
  end

  assign level = sync_q[P_STAGES-1];
  assign rise  = sync_q[P_STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[P_STAGES-1] & prev_q;

endmodule

// File: rtl/syn_adc_i2s_rx.sv
// rtl/syn_adc_i2s_rx.sv - codec ADC I2S deserialiser to 32b stereo PCM with valid/ready
//
// Purpose: samples BCLK/ADCLRC/ADCDAT (async) in clk_ir, assembles {left,right}
//          words and offers them on a valid/ready output with sticky overflow.
// Ports:
//   clk_ir         in   system clock (>= 4x BCLK)
//   rst_il         in   synchronous active-low reset
//   en_ih          in   receiver enable
//   bclk_i         in   codec bit clock (async)
//   adc_lrc_i      in   codec L/R clock (async), 0=left 1=right
//   adc_dat_i      in   codec serial data (async)
//   pcm_data_ow    out  {left,right} sample pair
//   pcm_valid_ow   out  pcm_data_ow holds an unread pair
//   pcm_ready_ih   in   consumer accepts when valid&ready
//   ovrflw_ow      out  sticky: completed pair dropped because output was full
//   ovrflw_clr_ih  in   clears ovrflw_ow (a new overflow wins)
module syn_adc_i2s_rx
  import syn_global_pkg::*;
#(
  parameter int P_SYNC_STAGES = 2,
  parameter int P_CH_W        = P_16B_W,
  parameter int P_PCM_W       = P_32B_W
) (
  input  logic               clk_ir,
  input  logic               rst_il,
  input  logic               en_ih,
  input  logic               bclk_i,
  input  logic               adc_lrc_i,
  input  logic               adc_dat_i,
  output logic [P_PCM_W-1:0] pcm_data_ow,
  output logic               pcm_valid_ow,
  input  logic               pcm_ready_ih,
  output logic               ovrflw_ow,
  input  logic               ovrflw_clr_ih
);

  localparam int                CNT_W    = $clog2(P_CH_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(P_CH_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CH_W - 1);

  logic bclk_lvl, bclk_rise, bclk_fall;
  logic lrc_lvl, lrc_rise, lrc_fall;
  logic [P_SYNC_STAGES-1:0] dat_sync_q;
  logic dat;

  syn_sync_edge #(.P_STAGES(P_SYNC_STAGES)) u_sync_bclk (
    .clk  (clk_ir),
    .rst_l(rst_il),
    .din  (bclk_i),
    .level(bclk_lvl),
    .rise (bclk_rise),
    .fall (bclk_fall)
  );

  syn_sync_edge #(.P_STAGES(P_SYNC_STAGES)) u_sync_lrc (
    .clk  (clk_ir),
    .rst_l(rst_il),
    .din  (adc_lrc_i),
    .level(lrc_lvl),
    .rise (lrc_rise),
    .fall (lrc_fall)
  );

  // Only edge information is used from BCLK and only pulses from LRC.
  logic unused_sig;
  assign unused_sig = bclk_lvl ^ bclk_fall ^ lrc_lvl;

  // Same depth as BCLK so DAT is aligned with the bclk_rise pulse.
  always_ff @(posedge clk_ir) begin
    if (!rst_il) dat_sync_q <= '0;
    else         dat_sync_q <= {dat_sync_q[P_SYNC_STAGES-2:0], adc_dat_i};
  end
  assign dat = dat_sync_q[P_SYNC_STAGES-1];

  i2s_rx_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [P_CH_W-1:0] left_q, left_d, right_q, right_d;
  logic              tail_q, tail_d;
  logic              pair_done_q, pair_done_d;

  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      tail_q      <= 1'b0;
      pair_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      tail_q      <= tail_d;
      pair_done_q <= pair_done_d;
    end
  end

  // LRC moves on the BCLK falling edge, so its pulse arrives before the next
  // bclk_rise. The first bit after an LRC edge is the LSB of the previous slot;
  // when a slot is exactly P_CH_W wide that LSB still belongs to the channel
  // being shifted, which tail_q tracks instead of dropping the frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    right_d     = right_q;
    tail_d      = tail_q;
    pair_done_d = 1'b0;
    if (!en_ih) begin
      state_d = ST_IDLE;
      tail_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_WAIT_LRC;
        ST_WAIT_LRC: begin
          if (lrc_fall) state_d = ST_SKIP_L;
        end
        ST_SKIP_L: begin
          if (bclk_rise) begin
            state_d = ST_LEFT;
            cnt_d   = '0;
          end
        end
        ST_LEFT: begin
          if (lrc_rise) begin
            if (cnt_q == CNT_FULL)      state_d = ST_SKIP_R;
            else if (cnt_q == CNT_LAST) tail_d  = 1'b1;
            else                        state_d = ST_WAIT_LRC;
          end else if (bclk_rise) begin
            if (cnt_q != CNT_FULL) begin
              left_d = {left_q[P_CH_W-2:0], dat};
              cnt_d  = cnt_q + CNT_W'(1);
            end
            if (tail_q) begin
              state_d = ST_RIGHT;
              cnt_d   = '0;
              tail_d  = 1'b0;
            end
          end
        end
        ST_SKIP_R: begin
          if (bclk_rise) begin
            state_d = ST_RIGHT;
            cnt_d   = '0;
          end
        end
        ST_RIGHT: begin
          if (lrc_fall) begin
            if (cnt_q == CNT_LAST) tail_d  = 1'b1;
            else                   state_d = ST_SKIP_L;
          end else if (bclk_rise) begin
            right_d = {right_q[P_CH_W-2:0], dat};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              pair_done_d = 1'b1;
              cnt_d       = '0;
              tail_d      = 1'b0;
              // A tail bit was the next frame's delay bit, so go straight to LEFT.
              state_d     = tail_q ? ST_LEFT : ST_WAIT_LRC;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic accept;
  assign accept = pcm_valid_ow & pcm_ready_ih;

  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      pcm_data_ow  <= '0;
      pcm_valid_ow <= 1'b0;
      ovrflw_ow    <= 1'b0;
    end else begin
      if (pair_done_q && (!pcm_valid_ow || accept)) begin
        pcm_data_ow  <= {left_q, right_q};
        pcm_valid_ow <= 1'b1;
      end else if (accept) begin
        pcm_valid_ow <= 1'b0;
      end
      if (pair_done_q && pcm_valid_ow && !accept) ovrflw_ow <= 1'b1;
      else if (ovrflw_clr_ih)                     ovrflw_ow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_syn_adc_i2s_rx.sv
// tb/tb_syn_adc_i2s_rx.sv - directed table-driven bench for syn_adc_i2s_rx
module tb_syn_adc_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_il = 1'b0;
  logic        en_ih = 1'b0;
  logic        bclk_pin = 1'b0;
  logic        lrc_pin = 1'b1;
  logic        dat_pin = 1'b0;
  logic [31:0] pcm_data;
  logic        pcm_valid;
  logic        pcm_ready = 1'b1;
  logic        ovrflw;
  logic        ovrflw_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int gap_rise_cyc = 0;
  int valid_rise_cyc = -1;
  logic valid_prev = 1'b0;
  logic pend_dat = 1'b0;
  logic [31:0] got[$];

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        slot32;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  syn_adc_i2s_rx dut (
    .clk_ir       (clk),
    .rst_il       (rst_il),
    .en_ih        (en_ih),
    .bclk_i       (bclk_pin),
    .adc_lrc_i    (lrc_pin),
    .adc_dat_i    (dat_pin),
    .pcm_data_ow  (pcm_data),
    .pcm_valid_ow (pcm_valid),
    .pcm_ready_ih (pcm_ready),
    .ovrflw_ow    (ovrflw),
    .ovrflw_clr_ih(ovrflw_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observes just before the next active edge so valid/ready match the handshake.
  always @(negedge clk) begin
    #3;
    if (pcm_valid && !valid_prev) valid_rise_cyc = cyc;
    valid_prev = pcm_valid;
    if (pcm_valid && pcm_ready) got.push_back(pcm_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (got.size() > i) return got[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One BCLK period (8 clk): LRC/DAT change with the falling edge.
  task automatic send_bit(input logic lrc, input logic d);
    bclk_pin = 1'b0;
    lrc_pin  = lrc;
    dat_pin  = d;
    repeat (4) tick();
    bclk_pin = 1'b1;
    last_rise_cyc = cyc;
    repeat (4) tick();
  endtask

  // Data lags LRC by one BCLK (I2S delay).
  task automatic push(input logic lrc, input logic d);
    send_bit(lrc, pend_dat);
    pend_dat = d;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic slot32);
    int slot;
    slot = slot32 ? 32 : 16;
    for (int i = 0; i < slot; i++) push(1'b0, (i < 16) ? l[15-i] : 1'b1);
    for (int i = 0; i < slot; i++) push(1'b1, (i < 16) ? r[15-i] : 1'b1);
  endtask

  // Emits the right LSB, then parks LRC high so the next frame starts on a fall.
  task automatic gap();
    push(1'b0, 1'b0);
    gap_rise_cyc = last_rise_cyc;
    push(1'b1, 1'b0);
    push(1'b1, 1'b0);
  endtask

  initial begin
    vecs[0] = '{l: 16'hA55A, r: 16'h1234, slot32: 1'b0, exp_data: 32'hA55A_1234};
    vecs[1] = '{l: 16'h8001, r: 16'h7FFE, slot32: 1'b1, exp_data: 32'h8001_7FFE};
    vecs[2] = '{l: 16'hFFFF, r: 16'h0000, slot32: 1'b0, exp_data: 32'hFFFF_0000};
    vecs[3] = '{l: 16'h0001, r: 16'h8000, slot32: 1'b1, exp_data: 32'h0001_8000};
    vecs[4] = '{l: 16'h5A5A, r: 16'hC3C3, slot32: 1'b0, exp_data: 32'h5A5A_C3C3};

    // Reset with pins toggling
    en_ih = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      send_bit(i[0], ~i[0]);
      chk("rst_data", pcm_data, 32'h0);
      chk("rst_valid", {31'b0, pcm_valid}, 32'h0);
      chk("rst_ovrflw", {31'b0, ovrflw}, 32'h0);
    end
    send_bit(1'b1, 1'b0);
    rst_il = 1'b1;
    repeat (4) tick();

    // Table-driven frames, ready held high
    for (int k = 0; k < 5; k++) begin
      got.delete();
      valid_rise_cyc = -1;
      send_frame(vecs[k].l, vecs[k].r, vecs[k].slot32);
      gap();
      repeat (4) tick();
      chk($sformatf("vec%0d_count", k), 32'(got.size()), 32'd1);
      chk($sformatf("vec%0d_data", k), got_at(0), vecs[k].exp_data);
      if (!vecs[k].slot32)
        chk($sformatf("vec%0d_latency", k), 32'(valid_rise_cyc - gap_rise_cyc), 32'd4);
    end
    chk("ovrflw_idle", {31'b0, ovrflw}, 32'h0);

    // Back-pressure: three frames while ready=0
    got.delete();
    pcm_ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 1'b0);
    send_frame(16'h3333, 16'h4444, 1'b0);
    send_frame(16'h5555, 16'h6666, 1'b0);
    gap();
    repeat (4) tick();
    chk("bp_valid", {31'b0, pcm_valid}, 32'h1);
    chk("bp_data_held", pcm_data, 32'h1111_2222);
    chk("bp_ovrflw", {31'b0, ovrflw}, 32'h1);
    ovrflw_clr = 1'b1;
    tick();
    ovrflw_clr = 1'b0;
    tick();
    chk("bp_ovrflw_clr", {31'b0, ovrflw}, 32'h0);
    pcm_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drained", {31'b0, pcm_valid}, 32'h0);
    send_frame(16'h7777, 16'h8888, 1'b0);
    gap();
    repeat (4) tick();
    chk("bp_count", 32'(got.size()), 32'd2);
    chk("bp_first", got_at(0), 32'h1111_2222);
    chk("bp_next", got_at(1), 32'h7777_8888);

    // Short left channel (10 bits) then a good frame
    got.delete();
    for (int i = 0; i < 11; i++) push(1'b0, i[0]);
    for (int i = 0; i < 17; i++) push(1'b1, ~i[0]);
    send_frame(16'hBEEF, 16'h0F0F, 1'b0);
    gap();
    repeat (4) tick();
    chk("short_count", 32'(got.size()), 32'd1);
    chk("short_data", got_at(0), 32'hBEEF_0F0F);

    // Enable dropped mid right channel
    got.delete();
    for (int i = 0; i < 16; i++) push(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) push(1'b1, 1'b0);
    en_ih = 1'b0;
    repeat (3) tick();
    en_ih = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b1, 1'b1);
    gap();
    repeat (4) tick();
    chk("en_partial_count", 32'(got.size()), 32'd0);
    send_frame(16'h4321, 16'hFEDC, 1'b1);
    gap();
    repeat (4) tick();
    chk("en_resync_count", 32'(got.size()), 32'd1);
    chk("en_resync_data", got_at(0), 32'h4321_FEDC);
    chk("en_ovrflw", {31'b0, ovrflw}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
